adc_line_sampler: RTL and testbench



---
 rtl/line_sensor_pkg.sv | 21 ++
 rtl/adc_sclk_gen.sv | 41 ++++
 rtl/adc_line_sampler.sv | 133 +++++++++++++
 tb/tb_adc_line_sampler.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/line_sensor_pkg.sv
// Shared constants and enums for the line-sensor ADC front end and the
// downstream decision block.
package line_sensor_pkg;
  localparam int SAMPLE_W        = 12;
  localparam int FRAME_SCLKS     = 16;
  localparam int DATA_FIRST_EDGE = 5;
  localparam int ADDR_FIRST_EDGE = 3;
  localparam int ADDR_LAST_EDGE  = 5;
  localparam int NUM_CH          = 3;

  typedef enum logic [1:0] {CH_IDX_L, CH_IDX_C, CH_IDX_R} ch_idx_t;
  typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_GAP} state_t;

  function automatic ch_idx_t next_ch(input ch_idx_t c);
    case (c)
      CH_IDX_L: return CH_IDX_C;
      CH_IDX_C: return CH_IDX_R;
      default:  return CH_IDX_L;
    endcase
  endfunction
endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK generator: low half first, CLK_DIV clocks per half; parked high and
// phase-reset whenever run is low so each frame starts with a falling edge.
module adc_sclk_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sclk,
  output logic fall_tick,
  output logic rise_tick,
  output logic period_end
);
  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;
  logic          phase;
  logic          half_last;

  assign half_last = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!run) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (half_last) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

  assign sclk       = run ? phase : 1'b1;
  assign fall_tick  = run & ~phase & (cnt == '0);
  assign rise_tick  = run &  phase & (cnt == '0);
  assign period_end = run &  phase & half_last;
endmodule

// File: rtl/adc_line_sampler.sv
// ADC128S022 front end: round-robins L/C/R channels and publishes one
// coherent thresholded triplet per round.
module adc_line_sampler import line_sensor_pkg::*; #(
  parameter int         CLK_DIV = 10,
  parameter logic [2:0] CH_L    = 3'd5,
  parameter logic [2:0] CH_C    = 3'd6,
  parameter logic [2:0] CH_R    = 3'd7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] threshold,
  input  logic                adc_data,
  output logic                adc_cs_n,
  output logic                adc_sclk,
  output logic                adc_din,
  output logic [SAMPLE_W-1:0] sample_l,
  output logic [SAMPLE_W-1:0] sample_c,
  output logic [SAMPLE_W-1:0] sample_r,
  output logic [2:0]          line_bits,
  output logic                sample_valid
);
  localparam int EW = $clog2(FRAME_SCLKS + 1);
  localparam int GW = $clog2(2 * CLK_DIV);

  state_t                           state, state_nxt;
  logic [EW-1:0]                    edge_cnt, cur_edge;
  logic [GW-1:0]                    gap_cnt;
  ch_idx_t                          ptr, prev_ptr;
  logic                             primed;
  logic [NUM_CH-1:0]                have;
  logic [SAMPLE_W-1:0]              shreg;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]  hold;
  logic [2:0]                       cur_addr;
  logic run, fall_tick, rise_tick, period_end, frame_end, gap_end, publish;

  assign run      = (state == ST_FRAME);
  assign adc_cs_n = ~run;

  adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk(clk), .rst_n(rst_n), .run(run), .sclk(adc_sclk),
    .fall_tick(fall_tick), .rise_tick(rise_tick), .period_end(period_end)
  );

  assign frame_end = period_end && (edge_cnt == EW'(FRAME_SCLKS));
  assign gap_end   = (state == ST_GAP) && (gap_cnt == GW'(2 * CLK_DIV - 1));
  // Only the R word completes a round; L and C must already be held.
  assign publish   = frame_end && primed && (prev_ptr == CH_IDX_R)
                     && have[CH_IDX_L] && have[CH_IDX_C];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (enable) state_nxt = ST_FRAME;
      ST_FRAME: if (frame_end) state_nxt = ST_GAP;
      ST_GAP:   if (gap_end) state_nxt = enable ? ST_FRAME : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Edge index including a falling edge happening this cycle, so DIN
  // switches in the same clock as SCLK drops.
  always_comb begin
    cur_edge = edge_cnt + EW'(fall_tick);
    case (ptr)
      CH_IDX_L: cur_addr = CH_L;
      CH_IDX_C: cur_addr = CH_C;
      default:  cur_addr = CH_R;
    endcase
    adc_din = 1'b0;
    if (run) begin
      case (cur_edge)
        EW'(ADDR_FIRST_EDGE):     adc_din = cur_addr[2];
        EW'(ADDR_FIRST_EDGE + 1): adc_din = cur_addr[1];
        EW'(ADDR_LAST_EDGE):      adc_din = cur_addr[0];
        default:                  adc_din = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt     <= '0;
      gap_cnt      <= '0;
      ptr          <= CH_IDX_L;
      prev_ptr     <= CH_IDX_L;
      primed       <= 1'b0;
      have         <= '0;
      shreg        <= '0;
      hold         <= '0;
      sample_l     <= '0;
      sample_c     <= '0;
      sample_r     <= '0;
      line_bits    <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= publish;
      gap_cnt      <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
      edge_cnt     <= run ? edge_cnt + EW'(fall_tick) : '0;
      if (rise_tick && edge_cnt >= EW'(DATA_FIRST_EDGE))
        shreg <= {shreg[SAMPLE_W-2:0], adc_data};
      if (frame_end) begin
        if (primed) begin
          hold[prev_ptr] <= shreg;
          have[prev_ptr] <= 1'b1;
        end
        if (publish) begin
          have      <= '0;
          sample_l  <= hold[CH_IDX_L];
          sample_c  <= hold[CH_IDX_C];
          sample_r  <= shreg;
          line_bits <= {hold[CH_IDX_L] >= threshold,
                        hold[CH_IDX_C] >= threshold,
                        shreg >= threshold};
        end
        prev_ptr <= ptr;
        ptr      <= next_ch(ptr);
        primed   <= 1'b1;
      end
      // Leaving the run restarts the pipeline from L with a priming frame.
      if (gap_end && !enable) begin
        primed <= 1'b0;
        ptr    <= CH_IDX_L;
        have   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_adc_line_sampler.sv
// Bench: ADC128S022 pin model, frame-arithmetic reference model with a
// per-cycle compare process, and directed scenarios with literal checks.
module tb_adc_line_sampler;
  localparam int D  = 10;
  localparam int FP = 34 * D;
  localparam int FR = 32 * D;

  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, adc_data = 1'b0;
  logic [11:0] threshold = 12'h800;
  logic        adc_cs_n, adc_sclk, adc_din, sample_valid;
  logic [11:0] sample_l, sample_c, sample_r;
  logic [2:0]  line_bits;

  always #5 clk = ~clk;

  adc_line_sampler #(.CLK_DIV(D), .CH_L(3'd5), .CH_C(3'd6), .CH_R(3'd7)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .threshold(threshold),
    .adc_data(adc_data), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
    .adc_din(adc_din), .sample_l(sample_l), .sample_c(sample_c),
    .sample_r(sample_r), .line_bits(line_bits), .sample_valid(sample_valid)
  );

  int          total = 0, bad = 0, cyc = 0;
  logic [11:0] adc_val [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] chan_of(input int k);
    case (k % 3)
      0:       return 3'd5;
      1:       return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  // ADC pin model: DOUT changes on SCLK fall, DIN latched on SCLK rise,
  // address from one frame selects the word of the next.
  int         rcnt = 0;
  logic       ps = 1'b1, pc = 1'b1;
  logic [2:0] cur_a = 3'd0, nxt_a = 3'd0;
  always @(negedge clk) begin
    if (adc_cs_n) begin
      rcnt = 0;
      if (!pc) cur_a = nxt_a;
      adc_data = 1'b0;
    end else if (ps && !adc_sclk) begin
      adc_data = (rcnt + 1 >= 5) ? adc_val[cur_a][16 - (rcnt + 1)] : 1'b0;
    end else if (!ps && adc_sclk) begin
      rcnt++;
      if (rcnt >= 3 && rcnt <= 5) nxt_a[5 - rcnt] = adc_din;
    end
    ps = adc_sclk;
    pc = adc_cs_n;
  end

  // Reference model: frame k of a run starts at t0+k*FP; frames k>=3 with
  // k%3==0 return the R word and publish the three configured channel values.
  bit          m_idle = 1'b1;
  int          t0m = 0;
  logic [11:0] e_l = '0, e_c = '0, e_r = '0;
  logic [2:0]  e_bits = '0;
  bit          e_valid = 1'b0;
  always @(posedge clk) begin
    int e, rel, k;
    e = cyc;
    cyc = cyc + 1;
    e_valid = 1'b0;
    if (!rst_n) begin
      m_idle = 1'b1;
      e_l = '0; e_c = '0; e_r = '0; e_bits = '0;
    end else if (m_idle) begin
      if (enable) begin
        m_idle = 1'b0;
        t0m = e + 1;
      end
    end else begin
      rel = e - t0m;
      k = rel / FP;
      if (rel % FP == FR - 1 && k >= 3 && k % 3 == 0) begin
        e_valid = 1'b1;
        e_l = adc_val[5]; e_c = adc_val[6]; e_r = adc_val[7];
        e_bits = {e_l >= threshold, e_c >= threshold, e_r >= threshold};
      end
      if (rel % FP == FP - 1 && !enable) m_idle = 1'b1;
    end
  end

  always @(negedge clk) begin
    int rel, p, n;
    logic ecs, esc, edin;
    logic [2:0] a;
    if (rst_n) begin
      ecs = 1'b1; esc = 1'b1; edin = 1'b0;
      if (!m_idle) begin
        rel = cyc - t0m;
        p = rel % FP;
        if (p < FR) begin
          ecs = 1'b0;
          esc = ((p / D) % 2) == 1;
          n = p / (2 * D) + 1;
          a = chan_of(rel / FP);
          if (n >= 3 && n <= 5) edin = a[5 - n];
        end
      end
      check("cs_n", adc_cs_n, ecs);
      check("sclk", adc_sclk, esc);
      check("din", adc_din, edin);
      check("valid", sample_valid, e_valid);
      check("sample_l", sample_l, e_l);
      check("sample_c", sample_c, e_c);
      check("sample_r", sample_r, e_r);
      check("line_bits", line_bits, e_bits);
    end
  end

  task automatic wait_valid(input int lim, output int at);
    bit ok;
    ok = 1'b0;
    at = 0;
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      if (sample_valid) begin ok = 1'b1; at = cyc; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL valid_timeout: no pulse in %0d cycles, required one", lim);
    end
  endtask

  task automatic wait_cs(input logic lvl, input int lim);
    for (int n = 0; adc_cs_n !== lvl; n++) begin
      if (n > lim) begin
        total++; bad++;
        $display("FAIL cs_timeout: cs_n=%0b after %0d cycles, required %0b", adc_cs_n, lim, lvl);
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int tstart, tp, tp2, n;
    logic [2:0] a;
    for (int i = 0; i < 8; i++) adc_val[i] = 12'h3C3;
    adc_val[5] = 12'hA5C; adc_val[6] = 12'h123; adc_val[7] = 12'hFFF;

    repeat (3) @(negedge clk);
    check("rst_cs_n", adc_cs_n, 1'b1);
    check("rst_sclk", adc_sclk, 1'b1);
    check("rst_din", adc_din, 1'b0);
    check("rst_samples", {sample_l, sample_c, sample_r}, 36'h0);
    check("rst_bits", line_bits, 3'b000);
    check("rst_valid", sample_valid, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    enable = 1'b1;
    tstart = cyc + 1;
    wait_valid(1500, tp);
    check("first_latency", tp - tstart, 1340);
    check("first_l", sample_l, 12'hA5C);
    check("first_c", sample_c, 12'h123);
    check("first_r", sample_r, 12'hFFF);
    check("first_bits", line_bits, 3'b101);

    wait_valid(1100, tp2);
    check("valid_spacing", tp2 - tp, 1020);

    threshold = 12'hA5D;
    check("bits_hold_until_publish", line_bits, 3'b101);
    wait_valid(1100, tp);
    check("thr_above_l", line_bits, 3'b001);
    threshold = 12'hA5C;
    wait_valid(1100, tp);
    check("thr_equal_l", line_bits, 3'b101);
    threshold = 12'h123;
    wait_valid(1100, tp);
    check("thr_equal_c", line_bits, 3'b111);
    threshold = 12'h124;
    wait_valid(1100, tp);
    check("thr_minus1_c", line_bits, 3'b101);

    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (adc_cs_n == 1'b0) break;
      n++;
      @(negedge clk);
      if (i == 0) check("valid_width", sample_valid, 1'b0);
    end
    check("gap_len", n, 20);

    // drop enable at falling edge 8 of the frame that just started
    wait_cs(1'b0, 400);
    repeat (14 * D) @(negedge clk);
    enable = 1'b0;
    wait_cs(1'b1, 400);
    repeat (100) @(negedge clk);
    check("stopped_cs", adc_cs_n, 1'b1);

    adc_val[5] = 12'h800; adc_val[6] = 12'h7FF; adc_val[7] = 12'h000;
    threshold = 12'h800;
    enable = 1'b1;
    tstart = cyc + 1;
    wait_valid(1500, tp);
    check("reprime_latency", tp - tstart, 1340);
    check("run2_l", sample_l, 12'h800);
    check("run2_c", sample_c, 12'h7FF);
    check("run2_r", sample_r, 12'h000);
    check("run2_bits", line_bits, 3'b100);

    // asynchronous reset at falling edge 10 of a frame
    wait_cs(1'b0, 400);
    repeat (18 * D) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_cs_n", adc_cs_n, 1'b1);
    check("arst_sclk", adc_sclk, 1'b1);
    check("arst_din", adc_din, 1'b0);
    check("arst_samples", {sample_l, sample_c, sample_r}, 36'h0);
    check("arst_bits", line_bits, 3'b000);
    check("arst_valid", sample_valid, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    wait_cs(1'b0, 100);
    tstart = cyc;
    a = 3'b000;
    for (int r = 1; r <= 9 * D; r++) begin
      @(negedge clk);
      if (r == 5 * D) a[2] = adc_din;
      if (r == 7 * D) a[1] = adc_din;
      if (r == 9 * D) a[0] = adc_din;
    end
    check("addr_after_rst", a, 3'b101);
    wait_valid(1500, tp);
    check("rst_latency", tp - tstart, 1340);
    check("rst_l", sample_l, 12'h800);
    check("rst_bits2", line_bits, 3'b100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
